fdce_delay_line_hme: RTL and testbench
======================================

# fdce_delay_line_hme

Parametrised, clock-enabled register delay line: WIDTH-bit data plus a valid flag shifts through DEPTH stages. Output is taken from a runtime-selectable tap. It also supports flush and tracks occupancy. It sits in datapath retiming and latency-matching paths, where single enabled flops were previously chained by hand.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of stages (≥1)
- INIT, 0, WIDTH-bit reset value of every data stage
- SELW, (DEPTH>1 ? $clog2(DEPTH) : 1), tap select width (derived; do not override)
- CNTW, $clog2(DEPTH+1), occupancy count width (derived)

Ports:
- C  in  1  clock; all state updates on rising edge
- CLR_N  in  1  reset; synchronous, active-low
- CE  in  1  clock enable for shifting
- FLUSH  in  1  synchronous invalidate of all stages
- D  in  WIDTH  input data
- DV  in  1  input valid
- DP  in  1  input even-parity bit (used only with FDCE_DL_PARITY_EN)
- SEL  in  SELW  tap select; latency = SEL+1 enabled cycles
- Q  out  WIDTH  data of selected stage
- QV  out  1  valid of selected stage
- CNT  out  CNTW  number of valid stages in the whole chain, 0..DEPTH
- BUSY  out  1  CNT != 0
- PERR  out  1  parity error on selected stage

## Operation
- Stages s[0..DEPTH-1], each with data d[k], valid v[k] and, when the parity feature is enabled, p[k].
- Priority at each rising edge of C: reset > FLUSH > CE > hold.
- Reset (CLR_N=0): d[k]=INIT, v[k]=0, p[k]=^INIT, CNT=0.
- FLUSH=1: all v[k]=0 and CNT=0; d[k]/p[k] unchanged; D/DV that cycle are dropped, even with CE=1.
- CE=1 (no flush):
  - d[0]<=D, v[0]<=DV, p[0]<=DP.
  - d[k]<=d[k-1], v[k]<=v[k-1], p[k]<=p[k-1] for k≥1.
  - Data shifts regardless of DV.
- CE=0: all state holds; the inputs are ignored.
- Tap select is a combinational mux over registered stages:
  - Q=d[t], QV=v[t], with t = min(SEL, DEPTH-1).
  - Out-of-range SEL clamps to the last stage.
- A SEL change takes effect at the output in the same cycle, with no pipeline restart. Words may be repeated or skipped across the change; this is expected and the user's responsibility.
- CNT is a registered counter, not a popcount. On a CE shift: CNT_next = CNT + DV − v[DEPTH-1]. This must always equal popcount(v); verification checks it as an invariant.
- BUSY = (CNT != 0), combinational from the CNT register.
- DEPTH=1: SEL is 1 bit and is ignored (t=0).

## Timing
- Latency D→Q is SEL+1 CE-qualified rising edges. With CE held high, this is SEL+1 clock cycles.
- Throughput is one word per enabled cycle; there is no backpressure.
- Outputs are valid from the first edge after reset: Q=INIT, QV=0, CNT=0, BUSY=0, PERR=0.
- Reset mid-stream discards all in-flight words at that edge.
- FLUSH and DV=1 in the same cycle: the word is lost and CNT=0 next cycle.
- Reset, FLUSH and CE asserted together: the reset result applies.

## Configuration
- Macro: FDCE_DL_PARITY_EN.
- Defined:
  - p[k] registers exist and shift with the data.
  - PERR = QV & ((^Q) != p[t]), combinational.
  - Invalid stages never flag an error.
- Undefined:
  - No parity storage is built; DP is unused.
  - PERR is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset (WIDTH=8, DEPTH=4, INIT=8'hA5): hold CLR_N=0 two cycles → Q=8'hA5, QV=0, CNT=0, BUSY=0, PERR=0.
- Streaming latency: CE=1, SEL=2, drive D=1,2,3… with DV=1 → Q=1 with QV=1 exactly 3 cycles after the first word; CNT ramps 1,2,3,4 then holds at 4.
- CE gating: SEL=3, one word D=8'h3C, then CE toggled 1,0,0,1,1,1 → the word appears only after its 4th enabled edge; CNT is unchanged during CE=0 cycles.
- Flush priority: chain full (CNT=4), assert FLUSH=1, CE=1, DV=1, D=8'h77 for one cycle → next cycle CNT=0, QV=0, BUSY=0; d contents are unchanged (Q still shows the old data at the tap).
- SEL clamp and live change: DEPTH=3 with SEL=3 behaves as SEL=2. Switching SEL 2→0 mid-stream shows the stage-0 word the same cycle; the CNT==popcount(v) invariant holds throughout.
- Parity (FDCE_DL_PARITY_EN defined): inject D=8'h01 with DP=0 (wrong) at SEL=1 → PERR=1 exactly when that word is at the tap with QV=1; correct-parity words give PERR=0. With the macro undefined, PERR stays 0.

Source files
------------

// File: rtl/fdce_delay_line_hme.sv
`default_nettype none
// ============================================================================
// Module   : fdce_delay_line_hme
// Purpose  : Clock-enabled WIDTH x DEPTH delay line with runtime output tap,
//            synchronous flush and a registered occupancy count.
// Option   : define FDCE_DL_PARITY_EN to store and check per-stage even parity.
// Revision : 1.0 - initial release
// ============================================================================
module fdce_delay_line_hme #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               SELW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int               CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    input  logic             DP,
    input  logic [SELW-1:0]  SEL,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    output logic [CNTW-1:0]  CNT,
    output logic             BUSY,
    output logic             PERR
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CNTW-1:0]  cnt_q;
    logic [CNTW-1:0]  cnt_d;
    logic [SELW-1:0]  w_tap;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (FLUSH) begin
            // Data words stay in place; only their valid flags are dropped.
            valid_d = '0;
            cnt_d   = '0;
        end else if (CE) begin
            data_d[0]  = D;
            valid_d[0] = DV;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            cnt_d = cnt_q + CNTW'(DV) - CNTW'(valid_q[DEPTH-1]);
        end
    end

    always_ff @(posedge C) begin
        if (!CLR_N) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= INIT;
            end
            valid_q <= '0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        if (DEPTH > 1) begin : g_tap_mux
            localparam logic [SELW-1:0] c_LAST_STAGE = SELW'(DEPTH - 1);
            assign w_tap = (SEL > c_LAST_STAGE) ? c_LAST_STAGE : SEL;
        end else begin : g_tap_fixed
            logic w_unused_sel;
            assign w_unused_sel = ^SEL;
            assign w_tap        = '0;
        end
    endgenerate

    assign Q    = data_q[w_tap];
    assign QV   = valid_q[w_tap];
    assign CNT  = cnt_q;
    assign BUSY = (cnt_q != '0);

`ifdef FDCE_DL_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [DEPTH-1:0] par_d;

    always_comb begin
        par_d = par_q;
        if (!FLUSH && CE) begin
            par_d[0] = DP;
            for (int k = 1; k < DEPTH; k++) begin
                par_d[k] = par_q[k-1];
            end
        end
    end

    always_ff @(posedge C) begin
        if (!CLR_N) begin
            par_q <= {DEPTH{^INIT}};
        end else begin
            par_q <= par_d;
        end
    end

    assign PERR = QV & ((^Q) != par_q[w_tap]);
`else
    logic w_unused_dp;
    assign w_unused_dp = DP;
    assign PERR        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fdce_delay_line_hme.sv
`default_nettype none
// ============================================================================
// Module   : tb_fdce_delay_line_hme
// Purpose  : Self-checking bench for fdce_delay_line_hme (DEPTH 4 and DEPTH 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fdce_delay_line_hme;

    localparam logic [7:0] c_INIT = 8'hA5;
`ifdef FDCE_DL_PARITY_EN
    localparam int c_PERR_BAD = 1;
`else
    localparam int c_PERR_BAD = 0;
`endif

    logic       C = 1'b0;
    logic       CLR_N, CE, FLUSH, DV, DP;
    logic [7:0] D;
    logic [1:0] SEL;

    logic [7:0] q4, q3;
    logic       qv4, qv3, busy4, busy3, perr4, perr3;
    logic [2:0] cnt4;
    logic [1:0] cnt3;

    fdce_delay_line_hme #(.WIDTH(8), .DEPTH(4), .INIT(c_INIT)) u_dut4 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .FLUSH(FLUSH), .D(D), .DV(DV), .DP(DP),
        .SEL(SEL), .Q(q4), .QV(qv4), .CNT(cnt4), .BUSY(busy4), .PERR(perr4)
    );

    fdce_delay_line_hme #(.WIDTH(8), .DEPTH(3), .INIT(c_INIT)) u_dut3 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .FLUSH(FLUSH), .D(D), .DV(DV), .DP(DP),
        .SEL(SEL), .Q(q3), .QV(qv3), .CNT(cnt3), .BUSY(busy3), .PERR(perr3)
    );

    always #5 C = ~C;

    typedef struct {
        int         inst;
        logic [7:0] q;
        logic       qv;
        int         cnt;
        logic       perr;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] md [2][4];
    logic [3:0] mv [2];
    logic [3:0] mp [2];
    int         n_assert = 0;
    int         n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference stage model; occupancy is derived by popcount, not a counter.
    task model_edge(input int i, input int dep);
        if (!CLR_N) begin
            for (int k = 0; k < 4; k++) md[i][k] = c_INIT;
            mv[i] = '0;
            mp[i] = {4{^c_INIT}};
        end else if (FLUSH) begin
            mv[i] = '0;
        end else if (CE) begin
            for (int k = dep - 1; k >= 1; k--) begin
                md[i][k] = md[i][k-1];
                mv[i][k] = mv[i][k-1];
                mp[i][k] = mp[i][k-1];
            end
            md[i][0] = D;
            mv[i][0] = DV;
            mp[i][0] = DP;
        end
    endtask

    task push_exp(input int i, input int dep);
        int   t;
        exp_t e;
        t      = (int'(SEL) > dep - 1) ? dep - 1 : int'(SEL);
        e.inst = i;
        e.q    = md[i][t];
        e.qv   = mv[i][t];
        e.cnt  = 0;
        for (int k = 0; k < dep; k++) e.cnt += int'(mv[i][k]);
`ifdef FDCE_DL_PARITY_EN
        e.perr = e.qv & ((^e.q) != mp[i][t]);
`else
        e.perr = 1'b0;
`endif
        sb.push_back(e);
    endtask

    task compare_out();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.inst == 0) begin
                chk("d4_q",    32'(q4),    32'(e.q));
                chk("d4_qv",   32'(qv4),   32'(e.qv));
                chk("d4_cnt",  32'(cnt4),  32'(e.cnt));
                chk("d4_busy", 32'(busy4), 32'(e.cnt != 0));
                chk("d4_perr", 32'(perr4), 32'(e.perr));
            end else begin
                chk("d3_q",    32'(q3),    32'(e.q));
                chk("d3_qv",   32'(qv3),   32'(e.qv));
                chk("d3_cnt",  32'(cnt3),  32'(e.cnt));
                chk("d3_busy", 32'(busy3), 32'(e.cnt != 0));
                chk("d3_perr", 32'(perr3), 32'(e.perr));
            end
        end
    endtask

    task step(input logic clr, input logic ce, input logic fl, input logic [7:0] d,
              input logic dv, input logic dp, input logic [1:0] sel);
        @(negedge C);
        CLR_N = clr; CE = ce; FLUSH = fl; D = d; DV = dv; DP = dp; SEL = sel;
        model_edge(0, 4);
        model_edge(1, 3);
        push_exp(0, 4);
        push_exp(1, 3);
        @(posedge C);
        #1;
        compare_out();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        CLR_N = 1'b0; CE = 1'b0; FLUSH = 1'b0; D = '0; DV = 1'b0; DP = 1'b0; SEL = '0;

        // Reset held two cycles
        step(0, 0, 0, 8'h00, 0, 0, 2'd0);
        step(0, 0, 0, 8'h00, 0, 0, 2'd0);
        chk("rst_q",    32'(q4),    32'hA5);
        chk("rst_qv",   32'(qv4),   0);
        chk("rst_cnt",  32'(cnt4),  0);
        chk("rst_busy", 32'(busy4), 0);
        chk("rst_perr", 32'(perr4), 0);

        // Streaming latency, SEL=2
        step(1, 1, 0, 8'd1, 1, ^8'd1, 2'd2);
        step(1, 1, 0, 8'd2, 1, ^8'd2, 2'd2);
        chk("lat_early_qv", 32'(qv4), 0);
        step(1, 1, 0, 8'd3, 1, ^8'd3, 2'd2);
        chk("lat_q",   32'(q4),   1);
        chk("lat_qv",  32'(qv4),  1);
        chk("lat_cnt", 32'(cnt4), 3);
        step(1, 1, 0, 8'd4, 1, ^8'd4, 2'd2);
        step(1, 1, 0, 8'd5, 1, ^8'd5, 2'd2);
        step(1, 1, 0, 8'd6, 1, ^8'd6, 2'd2);
        chk("lat_cnt_hold", 32'(cnt4), 4);

        // Empty the chain, then CE gating with one word at SEL=3
        step(1, 1, 1, 8'h99, 1, 0, 2'd3);
        step(1, 1, 0, 8'h3C, 1, 0, 2'd3);
        step(1, 0, 0, 8'h00, 0, 0, 2'd3);
        step(1, 0, 0, 8'h00, 0, 0, 2'd3);
        chk("ce_cnt_hold", 32'(cnt4), 1);
        step(1, 1, 0, 8'h00, 0, 0, 2'd3);
        step(1, 1, 0, 8'h00, 0, 0, 2'd3);
        chk("ce_not_yet_qv", 32'(qv4), 0);
        step(1, 1, 0, 8'h00, 0, 0, 2'd3);
        chk("ce_q",  32'(q4),  32'h3C);
        chk("ce_qv", 32'(qv4), 1);

        // Flush beats CE and DV
        step(1, 1, 0, 8'h10, 1, ^8'h10, 2'd3);
        step(1, 1, 0, 8'h11, 1, ^8'h11, 2'd3);
        step(1, 1, 0, 8'h12, 1, ^8'h12, 2'd3);
        step(1, 1, 0, 8'h13, 1, ^8'h13, 2'd3);
        chk("fl_full_cnt", 32'(cnt4), 4);
        step(1, 1, 1, 8'h77, 1, ^8'h77, 2'd3);
        chk("fl_cnt",  32'(cnt4),  0);
        chk("fl_qv",   32'(qv4),   0);
        chk("fl_busy", 32'(busy4), 0);
        chk("fl_q",    32'(q4),    32'h10);

        // SEL clamp on DEPTH=3, then live SEL change to stage 0
        step(1, 1, 0, 8'h21, 1, ^8'h21, 2'd3);
        step(1, 1, 0, 8'h22, 1, ^8'h22, 2'd3);
        step(1, 1, 0, 8'h23, 1, ^8'h23, 2'd3);
        step(1, 1, 0, 8'h24, 1, ^8'h24, 2'd3);
        chk("clamp_q3",   32'(q3),   32'h22);
        chk("clamp_cnt3", 32'(cnt3), 3);
        chk("clamp_q4",   32'(q4),   32'h21);
        @(negedge C);
        SEL = 2'd0;
        CE  = 1'b0;
        #1;
        chk("live_q4",  32'(q4),  32'h24);
        chk("live_q3",  32'(q3),  32'h24);
        chk("live_qv4", 32'(qv4), 1);

        // Parity: 01 carries a wrong parity bit
        step(1, 1, 0, 8'h03, 1, 0, 2'd1);
        step(1, 1, 0, 8'h01, 1, 0, 2'd1);
        chk("par_good0", 32'(perr4), 0);
        step(1, 1, 0, 8'h07, 1, 1, 2'd1);
        chk("par_bad_qv", 32'(qv4),   1);
        chk("par_bad",    32'(perr4), 32'(c_PERR_BAD));
        step(1, 1, 0, 8'h00, 0, 0, 2'd1);
        chk("par_good1", 32'(perr4), 0);

        // Reset, flush and CE together mid-stream
        step(1, 1, 0, 8'h55, 1, 0, 2'd1);
        step(0, 1, 1, 8'h66, 1, 1, 2'd1);
        chk("rfc_q",   32'(q4),   32'hA5);
        chk("rfc_cnt", 32'(cnt4), 0);
        step(1, 0, 0, 8'h00, 0, 0, 2'd0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
